param_bist_controller: RTL and testbench

PARAM_BIST_CONTROLLER -- requirements
Module: param_bist_controller

---
 rtl/param_bist_controller.sv | 217 +++++++++++++++++++++
 tb/tb_param_bist_controller.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_bist_controller.sv
// param_bist_controller
// Built-in self test controller wrapped around a WIDTH-bit ripple-carry adder
// (the circuit under test). In normal mode the adder is fed by the functional
// operands; during a BIST run an exhaustive counter drives every {a,b,cin}
// combination. The adder's response is compared against a behavioural
// reference and compacted into a rotate-and-XOR signature.
//
// Optional feature macro: BIST_FAULT_INJECT_EN
//   When defined, an extra input fault_inject forces adder sum bit 0 to a
//   stuck-at-0 so the self test has something to find. When undefined, the
//   port and forcing logic do not exist and the adder is fault-free.

module param_bist_controller #(
    parameter int WIDTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 testmode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 cin,
`ifdef BIST_FAULT_INJECT_EN
    input  logic                 fault_inject,
`endif
    output logic [WIDTH-1:0]     sum,
    output logic                 cout,
    output logic [2*WIDTH:0]     tpg_pattern,
    output logic                 busy,
    output logic                 done,
    output logic                 fault_detected,
    output logic [15:0]          fail_count,
    output logic [WIDTH:0]       signature
);

    // Pattern width is {a,b,cin}; the run visits every value exactly once.
    localparam int PW   = 2 * WIDTH + 1;
    localparam int NPAT = 2 ** PW;
    localparam logic [PW-1:0] LAST_PAT = PW'(NPAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     tpg_q, tpg_d;
    logic              fault_q, fault_d;
    logic [15:0]       fail_q, fail_d;
    logic [WIDTH:0]    sig_q, sig_d;

    // Decoded controls from the output process.
    logic              in_run;
    logic              in_done;
    logic              start_run;
    logic              step_run;

    // Adder inputs after the normal/test mux.
    logic [WIDTH-1:0]  cut_a;
    logic [WIDTH-1:0]  cut_b;
    logic              cut_cin;

    // Ripple-carry adder internals and the behavioural reference.
    logic [WIDTH:0]    carry;
    logic [WIDTH-1:0]  sum_raw;
    logic [WIDTH-1:0]  sum_cut;
    logic [WIDTH:0]    cut_resp;
    logic [WIDTH:0]    ref_resp;
    logic              mismatch;

    // State register: synchronous reset wins over everything, including a run.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: an abort (testmode low) takes precedence over finishing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (testmode) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!testmode) begin
                    state_d = IDLE;
                end else if (tpg_q == LAST_PAT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!testmode) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode: status flags plus the strobes that drive the datapath.
    always_comb begin
        in_run    = 1'b0;
        in_done   = 1'b0;
        start_run = 1'b0;
        step_run  = 1'b0;
        case (state_q)
            IDLE: begin
                start_run = testmode;
            end
            RUN: begin
                in_run   = 1'b1;
                step_run = testmode;
            end
            DONE: begin
                in_done = 1'b1;
            end
            default: begin
                in_run = 1'b0;
            end
        endcase
    end

    // Adder input mux: test patterns only while running, functional inputs otherwise.
    always_comb begin
        if (in_run) begin
            cut_a   = tpg_q[PW-1:WIDTH+1];
            cut_b   = tpg_q[WIDTH:1];
            cut_cin = tpg_q[0];
        end else begin
            cut_a   = a;
            cut_b   = b;
            cut_cin = cin;
        end
    end

    // Structural ripple-carry chain; this is the logic actually under test.
    assign carry[0] = cut_cin;
    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
        assign sum_raw[i]   = cut_a[i] ^ cut_b[i] ^ carry[i];
        assign carry[i+1]   = (cut_a[i] & cut_b[i]) | (carry[i] & (cut_a[i] ^ cut_b[i]));
    end

`ifdef BIST_FAULT_INJECT_EN
    // Stuck-at-0 on sum bit 0 while injection is requested.
    always_comb begin
        sum_cut    = sum_raw;
        sum_cut[0] = sum_raw[0] & ~fault_inject;
    end
`else
    // Fault-free adder.
    always_comb begin
        sum_cut = sum_raw;
    end
`endif

    // Reference model and comparison; the reference never sees injected faults.
    always_comb begin
        cut_resp = {carry[WIDTH], sum_cut};
        ref_resp = {1'b0, cut_a} + {1'b0, cut_b} + {{WIDTH{1'b0}}, cut_cin};
        mismatch = (cut_resp != ref_resp);
    end

    // Datapath next values: clear on run start, advance and accumulate per run cycle.
    always_comb begin
        tpg_d   = tpg_q;
        fault_d = fault_q;
        fail_d  = fail_q;
        sig_d   = sig_q;
        if (start_run) begin
            tpg_d   = '0;
            fault_d = 1'b0;
            fail_d  = '0;
            sig_d   = '0;
        end else if (step_run) begin
            tpg_d = tpg_q + PW'(1);
            sig_d = {sig_q[WIDTH-1:0], sig_q[WIDTH]} ^ cut_resp;
            if (mismatch) begin
                fault_d = 1'b1;
                if (fail_q != 16'hFFFF) begin
                    fail_d = fail_q + 16'd1;
                end
            end
        end
    end

    // Datapath registers; results persist through DONE, IDLE and aborts.
    always_ff @(posedge clock) begin
        if (reset) begin
            tpg_q   <= '0;
            fault_q <= 1'b0;
            fail_q  <= '0;
            sig_q   <= '0;
        end else begin
            tpg_q   <= tpg_d;
            fault_q <= fault_d;
            fail_q  <= fail_d;
            sig_q   <= sig_d;
        end
    end

    assign sum            = sum_cut;
    assign cout           = carry[WIDTH];
    assign tpg_pattern    = tpg_q;
    assign busy           = in_run;
    assign done           = in_done;
    assign fault_detected = fault_q;
    assign fail_count     = fail_q;
    assign signature      = sig_q;

endmodule

// File: tb/tb_param_bist_controller.sv
// Testbench for param_bist_controller.
// Two instances share the clock: a WIDTH=1 copy for the detailed sequences
// and a default WIDTH=4 copy for the long exhaustive run. Define
// BIST_FAULT_INJECT_EN to also exercise the stuck-at-0 fault run.

module tb_param_bist_controller;

   logic clock = 1'b0;
   logic reset;

   logic        tm1;
   logic [0:0]  a1, b1;
   logic        cin1;
   logic [0:0]  sum1;
   logic        cout1;
   logic [2:0]  tpg1;
   logic        busy1, done1, fault1;
   logic [15:0] fail1;
   logic [1:0]  sig1;

   logic        tm4;
   logic [3:0]  a4, b4;
   logic        cin4;
   logic [3:0]  sum4;
   logic        cout4;
   logic [8:0]  tpg4;
   logic        busy4, done4, fault4;
   logic [15:0] fail4;
   logic [4:0]  sig4;

`ifdef BIST_FAULT_INJECT_EN
   logic fi1 = 1'b0;
   logic fi4 = 1'b0;
`endif

   int checks = 0;
   int errors = 0;
   logic [31:0] expQ[$];

   typedef struct {
      logic       sel4;
      logic [3:0] a;
      logic [3:0] b;
      logic       cin;
      logic [4:0] expResp;
   } vec_t;

   vec_t vecs[8];

   param_bist_controller #(.WIDTH(1)) dut1 (
      .clock(clock), .reset(reset), .testmode(tm1),
      .a(a1), .b(b1), .cin(cin1),
`ifdef BIST_FAULT_INJECT_EN
      .fault_inject(fi1),
`endif
      .sum(sum1), .cout(cout1), .tpg_pattern(tpg1), .busy(busy1), .done(done1),
      .fault_detected(fault1), .fail_count(fail1), .signature(sig1)
   );

   param_bist_controller dut4 (
      .clock(clock), .reset(reset), .testmode(tm4),
      .a(a4), .b(b4), .cin(cin4),
`ifdef BIST_FAULT_INJECT_EN
      .fault_inject(fi4),
`endif
      .sum(sum4), .cout(cout4), .tpg_pattern(tpg4), .busy(busy4), .done(done4),
      .fault_detected(fault4), .fail_count(fail4), .signature(sig4)
   );

   // Free-running clock, period 10.
   always #5 clock = ~clock;

   // Watchdog so the bench always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic compareValue(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Pops the next scoreboard entry and compares it against the DUT value.
   task automatic checkOutput(input string name, input logic [31:0] act, output logic [31:0] expv);
      if (expQ.size() == 0) begin
         checks++;
         errors++;
         expv = '0;
         $display("[TB] FAIL %s: got %0h, expected nothing (scoreboard empty)", name, act);
      end else begin
         expv = expQ.pop_front();
         compareValue(name, act, expv);
      end
   endtask

   // Drives one normal-mode vector and pushes its expected {cout,sum}.
   task automatic applyStimulus(input vec_t v);
      if (v.sel4) begin
         a4 = v.a; b4 = v.b; cin4 = v.cin;
      end else begin
         a1 = v.a[0:0]; b1 = v.b[0:0]; cin1 = v.cin;
      end
      expQ.push_back({27'd0, v.expResp});
   endtask

   // Full WIDTH=1 run from IDLE; per-cycle pattern and response checks, then results.
   task automatic runFull1(input logic fiEn, input logic [15:0] expFail, input logic expFault);
      int busyCycles;
      logic [1:0] msig;
      logic [1:0] resp;
      logic [31:0] p;
      busyCycles = 0;
      msig = 2'b00;
      for (int i = 0; i < 8; i++) expQ.push_back(i);
      @(negedge clock);
      tm1 = 1'b1;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge clock);
         if (done1) break;
         if (busy1) begin
            busyCycles++;
            checkOutput("run1_tpg", {29'd0, tpg1}, p);
            resp = 2'(p[2]) + 2'(p[1]) + 2'(p[0]);
            if (fiEn) resp[0] = 1'b0;
            compareValue("run1_resp", {30'd0, cout1, sum1}, {30'd0, resp});
            msig = {msig[0], msig[1]} ^ resp;
         end
      end
      compareValue("run1_busy_cycles", busyCycles, 8);
      compareValue("run1_queue_drained", expQ.size(), 0);
      compareValue("run1_done", {31'd0, done1}, 1);
      compareValue("run1_busy_low", {31'd0, busy1}, 0);
      compareValue("run1_fault", {31'd0, fault1}, {31'd0, expFault});
      compareValue("run1_fail_count", {16'd0, fail1}, {16'd0, expFail});
      compareValue("run1_signature_model", {30'd0, sig1}, {30'd0, msig});
      compareValue("run1_signature", {30'd0, sig1}, 32'd3);
      expQ.delete();
   endtask

   initial begin
      int busyCycles;
      logic [4:0] msig4;
      logic [4:0] resp4;
      logic [31:0] p;

      vecs[0] = '{sel4: 1'b0, a: 4'd1,  b: 4'd0, cin: 1'b1, expResp: 5'b00010};
      vecs[1] = '{sel4: 1'b0, a: 4'd0,  b: 4'd0, cin: 1'b0, expResp: 5'b00000};
      vecs[2] = '{sel4: 1'b0, a: 4'd1,  b: 4'd1, cin: 1'b1, expResp: 5'b00011};
      vecs[3] = '{sel4: 1'b0, a: 4'd0,  b: 4'd1, cin: 1'b0, expResp: 5'b00001};
      vecs[4] = '{sel4: 1'b1, a: 4'd15, b: 4'd1, cin: 1'b0, expResp: 5'h10};
      vecs[5] = '{sel4: 1'b1, a: 4'd7,  b: 4'd8, cin: 1'b1, expResp: 5'h10};
      vecs[6] = '{sel4: 1'b1, a: 4'd5,  b: 4'd3, cin: 1'b0, expResp: 5'h08};
      vecs[7] = '{sel4: 1'b1, a: 4'd9,  b: 4'd9, cin: 1'b1, expResp: 5'h13};

      reset = 1'b1;
      tm1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
      tm4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
      repeat (2) @(negedge clock);

      // Reset state of both instances.
      compareValue("reset_busy1", {31'd0, busy1}, 0);
      compareValue("reset_done1", {31'd0, done1}, 0);
      compareValue("reset_tpg1", {29'd0, tpg1}, 0);
      compareValue("reset_sig1", {30'd0, sig1}, 0);
      compareValue("reset_fail1", {16'd0, fail1}, 0);
      compareValue("reset_fault1", {31'd0, fault1}, 0);
      compareValue("reset_busy4", {31'd0, busy4}, 0);
      compareValue("reset_tpg4", {23'd0, tpg4}, 0);
      reset = 1'b0;
      @(negedge clock);

      // Normal-mode adder vectors.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i]);
         #1;
         if (vecs[i].sel4) begin
            checkOutput("normal_resp4", {27'd0, cout4, sum4}, p);
            compareValue("normal_busy4", {31'd0, busy4}, 0);
         end else begin
            checkOutput("normal_resp1", {30'd0, cout1, sum1}, p);
            compareValue("normal_busy1", {31'd0, busy1}, 0);
            compareValue("normal_done1", {31'd0, done1}, 0);
         end
         @(negedge clock);
      end
      a1 = '0; b1 = '0; cin1 = 1'b0;

      // Fault-free full run.
      runFull1(1'b0, 16'd0, 1'b0);

      // testmode held after DONE must not restart.
      repeat (3) @(negedge clock);
      compareValue("hold_done", {31'd0, done1}, 1);
      compareValue("hold_busy", {31'd0, busy1}, 0);
      tm1 = 1'b0;
      @(negedge clock);
      compareValue("idle_done", {31'd0, done1}, 0);
      compareValue("idle_fail_kept", {16'd0, fail1}, 0);
      compareValue("idle_sig_kept", {30'd0, sig1}, 3);

      // Abort after three RUN cycles.
      tm1 = 1'b1;
      for (int i = 0; i < 3; i++) expQ.push_back(i);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         compareValue("abort_busy", {31'd0, busy1}, 1);
         checkOutput("abort_tpg", {29'd0, tpg1}, p);
      end
      @(negedge clock);
      tm1 = 1'b0;
      @(negedge clock);
      compareValue("abort_busy_low", {31'd0, busy1}, 0);
      compareValue("abort_done_low", {31'd0, done1}, 0);
      compareValue("abort_tpg_held", {29'd0, tpg1}, 3);
      compareValue("abort_sig_partial", {30'd0, sig1}, 3);
      compareValue("abort_fail", {16'd0, fail1}, 0);

      // Restart clears partial results.
      tm1 = 1'b1;
      @(negedge clock);
      compareValue("restart_busy", {31'd0, busy1}, 1);
      compareValue("restart_tpg", {29'd0, tpg1}, 0);
      compareValue("restart_sig", {30'd0, sig1}, 0);
      repeat (5) @(negedge clock);
      compareValue("midrun_tpg", {29'd0, tpg1}, 5);

      // Reset mid-run.
      reset = 1'b1;
      @(negedge clock);
      compareValue("rst_mid_busy", {31'd0, busy1}, 0);
      compareValue("rst_mid_done", {31'd0, done1}, 0);
      compareValue("rst_mid_tpg", {29'd0, tpg1}, 0);
      compareValue("rst_mid_sig", {30'd0, sig1}, 0);
      compareValue("rst_mid_fail", {16'd0, fail1}, 0);
      compareValue("rst_mid_resp", {30'd0, cout1, sum1}, 0);
      a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0;
      #1;
      compareValue("rst_comb_resp", {30'd0, cout1, sum1}, 2);
      reset = 1'b0;
      a1 = '0; b1 = '0;
      @(negedge clock);
      compareValue("fresh_busy", {31'd0, busy1}, 1);
      compareValue("fresh_tpg", {29'd0, tpg1}, 0);
      tm1 = 1'b0;
      @(negedge clock);
      compareValue("fresh_abort_busy", {31'd0, busy1}, 0);

`ifdef BIST_FAULT_INJECT_EN
      // Stuck-at-0 fault run.
      fi1 = 1'b1;
      runFull1(1'b1, 16'd4, 1'b1);
      tm1 = 1'b0;
      @(negedge clock);
      fi1 = 1'b0;
`endif

      // Default WIDTH=4 exhaustive run.
      busyCycles = 0;
      msig4 = '0;
      for (int i = 0; i < 512; i++) expQ.push_back(i);
      tm4 = 1'b1;
      for (int cyc = 0; cyc < 700; cyc++) begin
         @(negedge clock);
         if (done4) break;
         if (busy4) begin
            busyCycles++;
            checkOutput("run4_tpg", {23'd0, tpg4}, p);
            resp4 = {1'b0, p[8:5]} + {1'b0, p[4:1]} + {4'd0, p[0]};
            msig4 = {msig4[3:0], msig4[4]} ^ resp4;
         end
      end
      compareValue("run4_busy_cycles", busyCycles, 512);
      compareValue("run4_done", {31'd0, done4}, 1);
      compareValue("run4_fail", {16'd0, fail4}, 0);
      compareValue("run4_fault", {31'd0, fault4}, 0);
      compareValue("run4_signature", {27'd0, sig4}, {27'd0, msig4});
      tm4 = 1'b0;
      @(negedge clock);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
